// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight register writers and picks
// RUN / STALL / FLUSH / FREEZE each cycle, driving the pipeline enables.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_ifid,
  input  logic        valid_ifid,
  input  logic        wr_en_id,
  input  logic [2:0]  dst_id,
  input  logic        br_taken_ex,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        flush_ifid,
  output logic        idex_bubble,
  output logic        pipe_freeze,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    STALL  = 2'b01,
    FLUSH  = 2'b10,
    FREEZE = 2'b11
  } state_t;

  state_t state_q, state_d;

  // Index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB
  logic [2:0]      sb_v;
  logic [2:0][2:0] sb_reg;

  logic [4:0] opcode;
  logic [2:0] rs, rt;
  logic       rs_used, rt_used, rs_hit, rt_hit, hazard;
  logic       new_v;
  logic       unused_bits;

  assign opcode = instr_ifid[15:11];
  assign rs     = instr_ifid[10:8];
  assign rt     = instr_ifid[7:5];

  // MEM/WB is tracked but never compared: the register file writes before it reads
  assign unused_bits = ^{instr_ifid[4:0], sb_v[2], sb_reg[2]};

  assign rs_used = !(opcode == 5'b00000 || opcode == 5'b00001 ||
                     opcode == 5'b11000 || opcode == 5'b00100 ||
                     opcode == 5'b00110);
  assign rt_used = (opcode[4:3] == 2'b11 && opcode != 5'b11001) ||
                   opcode == 5'b10000 || opcode == 5'b10011;

  assign rs_hit = (sb_v[0] && sb_reg[0] == rs) || (sb_v[1] && sb_reg[1] == rs);
  assign rt_hit = (sb_v[0] && sb_reg[0] == rt) || (sb_v[1] && sb_reg[1] == rt);
  assign hazard = valid_ifid && ((rs_used && rs_hit) || (rt_used && rt_hit));

  always_comb begin
    state_d = RUN;
    if (rst)              state_d = RUN;
    else if (mem_busy)    state_d = FREEZE;
    else if (br_taken_ex) state_d = FLUSH;
    else if (hazard)      state_d = STALL;
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    flush_ifid  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    case (state_d)
      STALL: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
      FLUSH: begin
        flush_ifid  = 1'b1;
        idex_bubble = 1'b1;
      end
      FREEZE: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        pipe_freeze = 1'b1;
      end
      default: ;
    endcase
  end

  assign new_v = (state_d == RUN) && valid_ifid && wr_en_id;
  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      stall_cnt <= 16'd0;
      sb_v      <= 3'b000;
      sb_reg    <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != RUN && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (state_d != FREEZE) begin
        sb_v   <= {sb_v[1:0], new_v};
        sb_reg <= {sb_reg[1:0], dst_id};
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_ifid  input  16  instruction held in IF/ID.
REQ-005 valid_ifid  input  1  IF/ID holds a real instruction.
REQ-006 wr_en_id  input  1  decoded IF/ID instruction writes the register file.
REQ-007 dst_id  input  3  destination register of the IF/ID instruction.
REQ-008 br_taken_ex  input  1  branch/jump in EX resolved taken.
REQ-009 mem_busy  input  1  multi-cycle memory not ready; pipeline must freeze.
REQ-010 pc_en  output  1  PC write enable.
REQ-011 ifid_en  output  1  IF/ID write enable.
REQ-012 flush_ifid  output  1  load NOP into IF/ID.
REQ-013 idex_bubble  output  1  load NOP into ID/EX.
REQ-014 pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-015 state  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH, 11 FREEZE.
REQ-016 stall_cnt  output  16  saturating count of non-RUN cycles.

Function
REQ-017 The block SHALL keep a 3-entry scoreboard {v, reg[2:0]} for the ID/EX, EX/MEM and MEM/WB stages.
REQ-018 When pipe_freeze=0, the scoreboard SHALL shift each cycle: ID/EX -> EX/MEM -> MEM/WB, with MEM/WB discarded.
REQ-019 The new ID/EX entry SHALL be {valid_ifid & wr_en_id, dst_id} in RUN, and v=0 in STALL or FLUSH.
REQ-020 When pipe_freeze=1, the scoreboard SHALL hold its contents.
REQ-021 Rs (instr_ifid[10:8]) SHALL be used except for opcodes [15:11] = 00000, 00001, 11000, 00100, 00110.
REQ-022 Rt (instr_ifid[7:5]) SHALL be used when [15:14]=11 and [15:11]≠11001, or when [15:11] is 10000 or 10011.
REQ-023 hazard SHALL be valid_ifid AND a used Rs/Rt matching reg of a valid ID/EX or EX/MEM entry.
REQ-024 MEM/WB matches SHALL NOT cause a hazard, because the register file writes before it reads.
REQ-025 Next-state selection SHALL follow this priority:
- mem_busy -> FREEZE
- else br_taken_ex -> FLUSH
- else hazard -> STALL
- else RUN
REQ-026 Outputs SHALL be combinational from the current-cycle next-state selection, so a response appears in the same cycle as its cause.
REQ-027 RUN outputs SHALL be: pc_en=1, ifid_en=1, flush_ifid=0, idex_bubble=0, pipe_freeze=0.
REQ-028 STALL outputs SHALL be: pc_en=0, ifid_en=0, idex_bubble=1, others 0.
REQ-029 FLUSH outputs SHALL be: pc_en=1, ifid_en=1, flush_ifid=1, idex_bubble=1, pipe_freeze=0.
REQ-030 FLUSH SHALL last exactly one cycle per br_taken_ex pulse.
REQ-031 FREEZE outputs SHALL be: pc_en=0, ifid_en=0, pipe_freeze=1, flush_ifid=0, idex_bubble=0.
REQ-032 The state register SHALL load the selected next state every cycle, and the state output SHALL show the registered value (one cycle behind the outputs).
REQ-033 stall_cnt SHALL increment by 1 on every cycle whose selected state is not RUN, and SHALL saturate at 16'hFFFF.
REQ-034 br_taken_ex together with a hazard SHALL select FLUSH, with no stall.
REQ-035 br_taken_ex held through FREEZE SHALL produce FLUSH on the first cycle after mem_busy falls.
REQ-036 A hazard on the ID/EX entry SHALL give 2 STALL cycles, and a hazard on the EX/MEM entry SHALL give 1.
REQ-037 valid_ifid=0 SHALL never cause a stall.

Reset
REQ-038 While rst=1, independent of clk:
- state=RUN
- all scoreboard v=0
- stall_cnt=0
- outputs at RUN values
REQ-039 Reset asserted mid-STALL or mid-FREEZE SHALL return the block to RUN immediately, with no residual stall after release.

Verification
REQ-040 Bench scenario: ADD r3 (wr r3), then ADD r4,r3,r1 in IF/ID -> idex_bubble=1 for 2 cycles, then RUN; stall_cnt=2.
REQ-041 Bench scenario: writer r2, one independent instruction, then reader of r2 as Rt via ST (10000) -> exactly 1 STALL cycle.
REQ-042 Bench scenario: LBI (11000) with Rs field = 3 while r3 is pending -> no stall.
REQ-043 Bench scenario: br_taken_ex=1 and hazard=1 in the same cycle -> flush_ifid=1, idex_bubble=1, pc_en=1 for 1 cycle; next cycle RUN with the scoreboard ID/EX entry v=0.
REQ-044 Bench scenario: mem_busy=1 for 3 cycles during a pending stall -> pipe_freeze=1 and scoreboard frozen for 3 cycles, then the remaining stall cycles resume; stall_cnt counts all of them.
REQ-045 Bench scenario: rst pulsed in the middle of a STALL -> state=00, stall_cnt=0, pc_en=1 asynchronously.
